// File: rtl/sc_regtimer_prescaled.sv
// -----------------------------------------------------------------------------
// sc_regtimer_prescaled
//
// Prescaled up/down modulo timer register used for game-time and speed
// bookkeeping. The 50 MHz clock is divided by RegTIMER_PRESCALE to make a count
// tick; each tick steps a modulo-RegTIMER_MODULO counter up or down. The counter
// either wraps or saturates at the bound, and raises a one-cycle terminal-count
// pulse whenever a tick lands on the bound.
//
// Ports
//   SC_RegTIMER_CLOCK_50          in   system clock, rising edge
//   SC_RegTIMER_RESET_InHigh      in   synchronous reset, active high
//   SC_RegTIMER_clear_InLow       in   synchronous clear of count + prescaler
//   SC_RegTIMER_load_InLow        in   parallel load of SC_RegTIMER_data_InBUS
//   SC_RegTIMER_data_InBUS        in   load value (clamped to MODULO-1)
//   SC_RegTIMER_upcount_InLow     in   count enable, gates the prescaler
//   SC_RegTIMER_direction_InHigh  in   1 = count up, 0 = count down
//   SC_RegTIMER_data_OutBUS       out  registered count value
//   SC_RegTIMER_tc_Out            out  registered terminal-count pulse
//   SC_RegTIMER_atbound_Out       out  registered "count sits at the bound for
//                                      the current direction" level
//
// Edge priority: reset > clear > load > count.
// -----------------------------------------------------------------------------
module sc_regtimer_prescaled #(
   parameter int RegTIMER_DATAWIDTH     = 8,
   parameter int RegTIMER_MODULO        = 100,
   parameter int RegTIMER_PRESCALE      = 50000000,
   parameter int RegTIMER_PRESCALEWIDTH = 26,
   parameter int RegTIMER_SATURATE      = 0
) (
   input  logic                          SC_RegTIMER_CLOCK_50,
   input  logic                          SC_RegTIMER_RESET_InHigh,
   input  logic                          SC_RegTIMER_clear_InLow,
   input  logic                          SC_RegTIMER_load_InLow,
   input  logic [RegTIMER_DATAWIDTH-1:0] SC_RegTIMER_data_InBUS,
   input  logic                          SC_RegTIMER_upcount_InLow,
   input  logic                          SC_RegTIMER_direction_InHigh,
   output logic [RegTIMER_DATAWIDTH-1:0] SC_RegTIMER_data_OutBUS,
   output logic                          SC_RegTIMER_tc_Out,
   output logic                          SC_RegTIMER_atbound_Out
);

   localparam int DW = RegTIMER_DATAWIDTH;
   localparam int PW = RegTIMER_PRESCALEWIDTH;

   // MODULO may equal 2^DW, so the range compare needs one extra bit.
   localparam logic [DW:0]   C_MOD   = (DW+1)'(RegTIMER_MODULO);
   localparam logic [DW-1:0] C_MAX   = DW'(RegTIMER_MODULO - 1);
   localparam logic [PW-1:0] C_PLAST = PW'(RegTIMER_PRESCALE - 1);
   localparam logic          C_SAT   = (RegTIMER_SATURATE != 0);

   // State
   logic [DW-1:0] r_count;
   logic [PW-1:0] r_presc;
   logic          r_tc;
   logic          r_atbound;

   // Next-state
   logic          w_enable;
   logic          w_tick;
   logic [DW-1:0] w_load_val;
   logic [DW-1:0] w_count_nxt;
   logic [PW-1:0] w_presc_nxt;
   logic          w_tc_nxt;
   logic          w_atbound_nxt;
   logic          w_atbound_rst;

   assign w_enable = ~SC_RegTIMER_upcount_InLow;

   // A tick is the enabled cycle in which the prescaler wraps. With
   // PRESCALE = 1 the last value is 0, so every enabled cycle ticks.
   assign w_tick = w_enable && (r_presc == C_PLAST);

   // Loads beyond the range are clamped so no illegal value is ever stored.
   assign w_load_val = ({1'b0, SC_RegTIMER_data_InBUS} >= C_MOD) ? C_MAX
                                                                 : SC_RegTIMER_data_InBUS;

   // Clear / load / count. Reset is handled in the register process and
   // overrides whatever is computed here.
   always_comb begin
      w_count_nxt = r_count;
      w_presc_nxt = r_presc;
      w_tc_nxt    = 1'b0;

      if (!SC_RegTIMER_clear_InLow) begin
         w_count_nxt = '0;
         w_presc_nxt = '0;
      end else if (!SC_RegTIMER_load_InLow) begin
         // Restarting the prescaler means a full period follows every load.
         w_count_nxt = w_load_val;
         w_presc_nxt = '0;
      end else if (w_enable) begin
         if (w_tick) begin
            w_presc_nxt = '0;
            if (SC_RegTIMER_direction_InHigh) begin
               if (r_count == C_MAX) begin
                  w_tc_nxt    = 1'b1;
                  w_count_nxt = C_SAT ? r_count : '0;
               end else begin
                  w_count_nxt = r_count + DW'(1);
               end
            end else begin
               if (r_count == '0) begin
                  w_tc_nxt    = 1'b1;
                  w_count_nxt = C_SAT ? r_count : C_MAX;
               end else begin
                  w_count_nxt = r_count - DW'(1);
               end
            end
         end else begin
            w_presc_nxt = r_presc + PW'(1);
         end
      end
   end

   // atbound tracks the value being written together with the direction
   // sampled on the same edge, so it always agrees with data_OutBUS.
   assign w_atbound_nxt = SC_RegTIMER_direction_InHigh ? (w_count_nxt == C_MAX)
                                                       : (w_count_nxt == '0);

   // After reset the count is 0; that is the bound only when counting down
   // (MODULO >= 2 keeps MODULO-1 away from 0).
   assign w_atbound_rst = ~SC_RegTIMER_direction_InHigh;

   always_ff @(posedge SC_RegTIMER_CLOCK_50) begin
      if (SC_RegTIMER_RESET_InHigh) begin
         r_count   <= '0;
         r_presc   <= '0;
         r_tc      <= 1'b0;
         r_atbound <= w_atbound_rst;
      end else begin
         r_count   <= w_count_nxt;
         r_presc   <= w_presc_nxt;
         r_tc      <= w_tc_nxt;
         r_atbound <= w_atbound_nxt;
      end
   end

   assign SC_RegTIMER_data_OutBUS = r_count;
   assign SC_RegTIMER_tc_Out      = r_tc;
   assign SC_RegTIMER_atbound_Out = r_atbound;

endmodule

// File: tb/tb_sc_regtimer_prescaled.sv
// -----------------------------------------------------------------------------
// tb_sc_regtimer_prescaled
//
// Self-checking bench for sc_regtimer_prescaled with WIDTH = 4, MODULO = 10,
// PRESCALE = 4. Two instances share all inputs: one wraps, one saturates.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at that same point, i.e. well away from the active edge.
// -----------------------------------------------------------------------------
module tb_sc_regtimer_prescaled;

   localparam int W  = 4;
   localparam int MD = 10;
   localparam int PS = 4;

   logic         clk = 1'b0;
   logic         rst, clr_n, ld_n, en_n, dir;
   logic [W-1:0] data;
   logic [W-1:0] cnt_w, cnt_s;
   logic         tc_w, tc_s, atb_w, atb_s;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sc_regtimer_prescaled #(
      .RegTIMER_DATAWIDTH(W), .RegTIMER_MODULO(MD), .RegTIMER_PRESCALE(PS),
      .RegTIMER_PRESCALEWIDTH(3), .RegTIMER_SATURATE(0)
   ) u_wrap (
      .SC_RegTIMER_CLOCK_50(clk), .SC_RegTIMER_RESET_InHigh(rst),
      .SC_RegTIMER_clear_InLow(clr_n), .SC_RegTIMER_load_InLow(ld_n),
      .SC_RegTIMER_data_InBUS(data), .SC_RegTIMER_upcount_InLow(en_n),
      .SC_RegTIMER_direction_InHigh(dir), .SC_RegTIMER_data_OutBUS(cnt_w),
      .SC_RegTIMER_tc_Out(tc_w), .SC_RegTIMER_atbound_Out(atb_w)
   );

   sc_regtimer_prescaled #(
      .RegTIMER_DATAWIDTH(W), .RegTIMER_MODULO(MD), .RegTIMER_PRESCALE(PS),
      .RegTIMER_PRESCALEWIDTH(3), .RegTIMER_SATURATE(1)
   ) u_sat (
      .SC_RegTIMER_CLOCK_50(clk), .SC_RegTIMER_RESET_InHigh(rst),
      .SC_RegTIMER_clear_InLow(clr_n), .SC_RegTIMER_load_InLow(ld_n),
      .SC_RegTIMER_data_InBUS(data), .SC_RegTIMER_upcount_InLow(en_n),
      .SC_RegTIMER_direction_InHigh(dir), .SC_RegTIMER_data_OutBUS(cnt_s),
      .SC_RegTIMER_tc_Out(tc_s), .SC_RegTIMER_atbound_Out(atb_s)
   );

   typedef struct {
      logic         rst, clr_n, ld_n;
      logic [W-1:0] data;
      logic         en_n, dir;
      logic [W-1:0] cnt;
      logic         tc, atb;
      string        nm;
   } vec_t;

   vec_t tv[$];

   function automatic vec_t mk(input logic r, input logic c, input logic l,
                               input int d, input logic e, input logic di,
                               input int cnt, input logic tc, input logic atb,
                               input string nm);
      vec_t v;
      v.rst = r; v.clr_n = c; v.ld_n = l; v.data = W'(d); v.en_n = e; v.dir = di;
      v.cnt = W'(cnt); v.tc = tc; v.atb = atb; v.nm = nm;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic c, input logic l, input int d,
                       input logic e, input logic di);
      rst = r; clr_n = c; ld_n = l; data = W'(d); en_n = e; dir = di;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; clr_n = 1'b1; ld_n = 1'b1; en_n = 1'b1; dir = 1'b1; data = '0;

      // ---- Reset state, counting up ----
      @(posedge clk); #1;
      step(1, 1, 1, 0, 1, 1);
      chk("rst_cnt_w", 32'(cnt_w), 0);
      chk("rst_tc_w",  32'(tc_w),  0);
      chk("rst_atb_w", 32'(atb_w), 0);
      chk("rst_cnt_s", 32'(cnt_s), 0);
      chk("rst_tc_s",  32'(tc_s),  0);

      // ---- Up count for 48 enabled cycles, both end behaviours ----
      for (int k = 1; k <= 48; k++) begin
         int ew, es;
         logic tw, ts;
         step(0, 1, 1, 0, 0, 1);
         ew = (k / PS) % MD;
         es = (k / PS > MD - 1) ? MD - 1 : k / PS;
         tw = (k % PS == 0) && (ew == 0);
         ts = (k % PS == 0) && (k / PS >= MD);
         chk($sformatf("up_cnt_w[%0d]", k), 32'(cnt_w), ew);
         chk($sformatf("up_tc_w[%0d]",  k), 32'(tc_w),  32'(tw));
         chk($sformatf("up_atb_w[%0d]", k), 32'(atb_w), 32'(ew == MD - 1));
         chk($sformatf("up_cnt_s[%0d]", k), 32'(cnt_s), es);
         chk($sformatf("up_tc_s[%0d]",  k), 32'(tc_s),  32'(ts));
         chk($sformatf("up_atb_s[%0d]", k), 32'(atb_s), 32'(es == MD - 1));
      end

      // ---- Directed vector table (wrap instance) ----
      //            rst clr ld  d  en dir  cnt tc atb
      tv.push_back(mk(1, 1, 1,  0, 1, 0,   0, 0, 1, "rst_dir0"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   0, 0, 1, "dn_p1"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   0, 0, 1, "dn_p2"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   0, 0, 1, "dn_p3"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   9, 1, 0, "dn_wrap"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   9, 0, 0, "dn_tc_drop"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   9, 0, 0, "dn_p2b"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   9, 0, 0, "dn_p3b"));
      tv.push_back(mk(0, 1, 0,  7, 0, 1,   7, 0, 0, "ld7_notick"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   7, 0, 0, "ld_p1"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   7, 0, 0, "ld_p2"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   7, 0, 0, "ld_p3"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   8, 0, 0, "ld_step8"));
      tv.push_back(mk(0, 1, 0, 12, 1, 1,   9, 0, 1, "ld12_clamp"));
      tv.push_back(mk(0, 1, 0, 10, 1, 1,   9, 0, 1, "ld10_clamp"));
      tv.push_back(mk(0, 1, 0,  5, 1, 1,   5, 0, 0, "ld5"));
      tv.push_back(mk(0, 0, 0,  3, 0, 1,   0, 0, 0, "clr_over_ld"));
      tv.push_back(mk(0, 0, 1,  0, 0, 0,   0, 0, 1, "clr_hold1"));
      tv.push_back(mk(0, 0, 1,  0, 0, 0,   0, 0, 1, "clr_hold2"));
      tv.push_back(mk(0, 0, 1,  0, 0, 0,   0, 0, 1, "clr_hold3"));
      tv.push_back(mk(0, 1, 0,  4, 1, 1,   4, 0, 0, "ld4"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   4, 0, 0, "gap_p1"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   4, 0, 0, "gap_p2"));
      tv.push_back(mk(0, 1, 1,  0, 1, 1,   4, 0, 0, "gap_hold1"));
      tv.push_back(mk(0, 1, 1,  0, 1, 1,   4, 0, 0, "gap_hold2"));
      tv.push_back(mk(0, 1, 1,  0, 1, 1,   4, 0, 0, "gap_hold3"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   4, 0, 0, "gap_p3"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   5, 0, 0, "gap_tick"));
      tv.push_back(mk(0, 1, 0,  6, 0, 1,   6, 0, 0, "ld6"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   6, 0, 0, "r6_p1"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   6, 0, 0, "r6_p2"));
      tv.push_back(mk(1, 1, 1,  0, 0, 1,   0, 0, 0, "rst_mid"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   0, 0, 0, "rst_p1"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   0, 0, 0, "rst_p2"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   0, 0, 0, "rst_p3"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   1, 0, 0, "rst_restart"));
      tv.push_back(mk(0, 1, 1,  0, 0, 1,   1, 0, 0, "dir_p1"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   1, 0, 0, "dir_p2"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   1, 0, 0, "dir_p3"));
      tv.push_back(mk(0, 1, 1,  0, 0, 0,   0, 0, 1, "dir_change"));

      foreach (tv[i]) begin
         step(tv[i].rst, tv[i].clr_n, tv[i].ld_n, int'(tv[i].data), tv[i].en_n, tv[i].dir);
         chk({tv[i].nm, "_cnt"}, 32'(cnt_w), 32'(tv[i].cnt));
         chk({tv[i].nm, "_tc"},  32'(tc_w),  32'(tv[i].tc));
         chk({tv[i].nm, "_atb"}, 32'(atb_w), 32'(tv[i].atb));
      end

      // ---- Saturate at the down bound: tc repeats at the tick rate ----
      step(1, 1, 1, 0, 1, 0);
      chk("sdn_rst_atb_s", 32'(atb_s), 1);
      for (int k = 1; k <= 9; k++) begin
         step(0, 1, 1, 0, 0, 0);
         chk($sformatf("sdn_cnt_s[%0d]", k), 32'(cnt_s), 0);
         chk($sformatf("sdn_tc_s[%0d]",  k), 32'(tc_s),  32'(k % PS == 0));
         chk($sformatf("sdn_atb_s[%0d]", k), 32'(atb_s), 1);
      end
      // Wrap instance saw the same stimulus: 0 -> 9 on the first tick, 8 on the second.
      chk("sdn_cnt_w", 32'(cnt_w), 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
